spi_cmd_sequencer: RTL
======================

// Module: spi_cmd_sequencer
// PURPOSE
//  Command sequencer on the i_Clk side of the 16-bit SPI slave. Decodes each received
//  word (RX_DV/RX_Data) into a register write, a register read or a sensor measurement.
//  Runs the register-bank or sensor handshake, then loads the reply word into the
//  slave's TX path, so the master reads the reply in its next SPI frame.
// PARAMETERS
//  DATA_LEN    16       SPI word width; must be >= 16 (opcode/address/data fields fixed)
//  TIMEOUT_CYC 1023     max i_Clk cycles waited for i_Reg_Ack / i_Meas_Done
//  ERR_WORD    16'hDEAD reply loaded on timeout; upper DATA_LEN-16 bits zero
// PORTS
//  i_Clk        in  1         system clock
//  i_Rst        in  1         synchronous reset, active-high
//  i_RX_DV      in  1         1-cycle pulse from SPI slave, word valid
//  i_RX_Data    in  DATA_LEN  received word
//  i_SPI_CS_n   in  1         raw SPI chip select (async; synchronised inside)
//  o_TX_DV      out 1         load strobe to slave; slave samples on its rising edge
//  o_TX_Data    out DATA_LEN  reply word to slave
//  o_Reg_Wr     out 1         1-cycle register write strobe
//  o_Reg_Rd     out 1         read request, held until i_Reg_Ack
//  o_Reg_Addr   out 6         register address
//  o_Reg_WData  out 8         write data
//  i_Reg_RData  in  8         read data, valid with i_Reg_Ack
//  i_Reg_Ack    in  1         read acknowledge
//  o_Meas_Start out 1         1-cycle sensor start pulse
//  i_Meas_Done  in  1         1-cycle done pulse
//  i_Meas_Data  in  DATA_LEN  result, valid with i_Meas_Done
//  o_Busy       out 1         state != IDLE
//  o_Overrun    out 1         sticky: an RX word was dropped while busy
//  o_Timeout    out 1         sticky: a handshake timed out
// BEHAVIOUR
//  Word decode: [15:14] op (00 NOP, 01 WRITE, 10 READ, 11 MEAS), [13:8] addr, [7:0] data.
//  Bits above [15] are ignored.
//  Reset (sync, any state): all outputs 0, o_TX_Data=0, state IDLE, sticky flags cleared.
//  CS sync: 2-FF synchroniser gives cs_s. The TX load happens only while cs_s=1, because
//   the slave ignores loads while CS_n is low.
//  FSM states: IDLE, RD_WAIT, MEAS_WAIT, TX_WAIT_CS, TX_SETUP, TX_STROBE.
//  IDLE, i_RX_DV=1:
//   NOP   -> stay IDLE. No outputs.
//   WRITE -> o_Reg_Wr=1 for the next cycle, with Addr/WData; stay IDLE. No reply.
//   READ  -> o_Reg_Rd=1, Addr driven; go to RD_WAIT.
//   MEAS  -> o_Meas_Start=1 for the next cycle; go to MEAS_WAIT.
//  RD_WAIT: on i_Reg_Ack, reply = {op=10, addr, i_Reg_RData}; o_Reg_Rd drops the same
//   cycle Ack is seen; go to TX_WAIT_CS.
//  MEAS_WAIT: on i_Meas_Done, reply = i_Meas_Data; go to TX_WAIT_CS.
//  Timeout: a counter resets on entry to RD_WAIT or MEAS_WAIT. When it reaches
//   TIMEOUT_CYC with no response: reply = ERR_WORD, o_Timeout set, o_Reg_Rd dropped,
//   go to TX_WAIT_CS. An Ack/Done arriving on the timeout cycle wins.
//  TX_WAIT_CS: wait for cs_s=1. Then go to TX_SETUP, driving o_TX_Data=reply.
//  TX_SETUP: one cycle with data stable and o_TX_DV=0. Then go to TX_STROBE.
//  TX_STROBE: o_TX_DV=1 for exactly one cycle. If cs_s=0 in this cycle, still pulse,
//   and return to TX_WAIT_CS to retry once CS rises. Otherwise return to IDLE.
//  o_TX_Data holds its value until the next reply is loaded.
//  Latency: READ word -> o_Reg_Rd is 1 cycle. Ack (with CS high) -> o_TX_DV is 3 cycles.
//  i_RX_DV in any state other than IDLE: word dropped, o_Overrun set. A word arriving in
//   the same cycle as FSM return-to-IDLE is also dropped; FSM accepts only in IDLE.
//  Stray i_Reg_Ack or i_Meas_Done outside the matching wait state: ignored.
// STRUCTURE
//  Shared package spi_cmd_pkg: opcode localparams (OP_NOP/WR/RD/MEAS), field bit
//   positions, FSM state encoding.
//  One sub-module: sync_2ff (2-flop synchroniser, reset value 1 = CS idle).
//   Everything else is inline.
// TESTING
//  1 WRITE: RX 16'h4A5C -> o_Reg_Wr 1 cycle, Addr=0x0A, WData=0x5C; no o_TX_DV.
//  2 READ, CS high: RX 16'h8300, Ack after 5 cycles with RData=0x77 ->
//    o_TX_Data=16'h8377 one cycle before a single-cycle o_TX_DV.
//  3 READ, CS low during Ack -> no o_TX_DV until CS rises.
//    Then o_TX_DV arrives 2 synchroniser + 2 cycles later.
//  4 MEAS with no Done, TIMEOUT_CYC=8 -> after 8 cycles, TX_Data=16'hDEAD,
//    o_Timeout=1, o_Meas_Start pulsed exactly once.
//  5 Second RX_DV while in RD_WAIT -> dropped, o_Overrun=1, first read completes normally.
//  6 i_Rst asserted in MEAS_WAIT -> next cycle all outputs 0, o_Busy=0.
//    A later Done pulse is ignored.

Source files
------------

// File: rtl/spi_cmd_pkg.sv
// Shared definitions for the SPI command sequencer: opcodes, word field
// positions and FSM state encoding.
package spi_cmd_pkg;

  localparam logic [1:0] OP_NOP  = 2'b00;
  localparam logic [1:0] OP_WR   = 2'b01;
  localparam logic [1:0] OP_RD   = 2'b10;
  localparam logic [1:0] OP_MEAS = 2'b11;

  localparam int OP_HI   = 15;
  localparam int OP_LO   = 14;
  localparam int ADDR_HI = 13;
  localparam int ADDR_LO = 8;
  localparam int DATA_HI = 7;
  localparam int DATA_LO = 0;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_RD_WAIT    = 3'd1,
    ST_MEAS_WAIT  = 3'd2,
    ST_TX_WAIT_CS = 3'd3,
    ST_TX_SETUP   = 3'd4,
    ST_TX_STROBE  = 3'd5
  } state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level; reset value selectable
// so an idle-high chip select powers up deselected.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic i_Clk,
  input  logic i_Rst,
  input  logic i_Async,
  output logic o_Sync
);

  logic meta_r;
  logic sync_r;

  // Metastability filter chain.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      meta_r <= RST_VAL;
      sync_r <= RST_VAL;
    end else begin
      meta_r <= i_Async;
      sync_r <= meta_r;
    end
  end

  assign o_Sync = sync_r;

endmodule

// File: rtl/spi_cmd_sequencer.sv
// Decodes words received by the SPI slave into register/sensor operations and
// loads each reply into the slave's TX path while chip select is deasserted.
module spi_cmd_sequencer
  import spi_cmd_pkg::*;
#(
  parameter int          DATA_LEN    = 16,
  parameter int          TIMEOUT_CYC = 1023,
  parameter logic [15:0] ERR_WORD    = 16'hDEAD
) (
  input  logic                i_Clk,
  input  logic                i_Rst,
  input  logic                i_RX_DV,
  input  logic [DATA_LEN-1:0] i_RX_Data,
  input  logic                i_SPI_CS_n,
  output logic                o_TX_DV,
  output logic [DATA_LEN-1:0] o_TX_Data,
  output logic                o_Reg_Wr,
  output logic                o_Reg_Rd,
  output logic [5:0]          o_Reg_Addr,
  output logic [7:0]          o_Reg_WData,
  input  logic [7:0]          i_Reg_RData,
  input  logic                i_Reg_Ack,
  output logic                o_Meas_Start,
  input  logic                i_Meas_Done,
  input  logic [DATA_LEN-1:0] i_Meas_Data,
  output logic                o_Busy,
  output logic                o_Overrun,
  output logic                o_Timeout
);

  localparam int                 CNT_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic                cs_s;
  state_e              state_r, state_next_s;
  logic [CNT_W-1:0]    cnt_r, cnt_next_s;
  logic [DATA_LEN-1:0] reply_r, reply_next_s;
  logic                timeout_hit_s;
  logic [1:0]          rx_op_s;
  logic                accept_s;
  logic [DATA_LEN-1:0] rd_reply_s;
  logic [DATA_LEN-1:0] err_reply_s;

  logic                tx_dv_r, reg_wr_r, reg_rd_r, meas_start_r;
  logic                busy_r, overrun_r, timeout_r;
  logic [DATA_LEN-1:0] tx_data_r;
  logic [5:0]          addr_r;
  logic [7:0]          wdata_r;

  sync_2ff #(.RST_VAL(1'b1)) u_cs_sync (
    .i_Clk   (i_Clk),
    .i_Rst   (i_Rst),
    .i_Async (i_SPI_CS_n),
    .o_Sync  (cs_s)
  );

  assign rx_op_s     = i_RX_Data[OP_HI:OP_LO];
  assign accept_s    = i_RX_DV && (state_r == ST_IDLE);
  assign rd_reply_s  = DATA_LEN'({OP_RD, addr_r, i_Reg_RData});
  assign err_reply_s = DATA_LEN'(ERR_WORD);

  // Next-state, wait counter and reply selection; a response on the last wait cycle beats the timeout.
  always_comb begin
    state_next_s  = state_r;
    cnt_next_s    = cnt_r;
    reply_next_s  = reply_r;
    timeout_hit_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        cnt_next_s = {CNT_W{1'b0}};
        if (accept_s && (rx_op_s == OP_RD)) begin
          state_next_s = ST_RD_WAIT;
        end else if (accept_s && (rx_op_s == OP_MEAS)) begin
          state_next_s = ST_MEAS_WAIT;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_RD_WAIT: begin
        if (i_Reg_Ack) begin
          reply_next_s = rd_reply_s;
          state_next_s = ST_TX_WAIT_CS;
        end else if (cnt_r == CNT_LAST) begin
          reply_next_s  = err_reply_s;
          timeout_hit_s = 1'b1;
          state_next_s  = ST_TX_WAIT_CS;
        end else begin
          cnt_next_s = cnt_r + CNT_W'(1);
        end
      end
      ST_MEAS_WAIT: begin
        if (i_Meas_Done) begin
          reply_next_s = i_Meas_Data;
          state_next_s = ST_TX_WAIT_CS;
        end else if (cnt_r == CNT_LAST) begin
          reply_next_s  = err_reply_s;
          timeout_hit_s = 1'b1;
          state_next_s  = ST_TX_WAIT_CS;
        end else begin
          cnt_next_s = cnt_r + CNT_W'(1);
        end
      end
      ST_TX_WAIT_CS: begin
        if (cs_s) begin
          state_next_s = ST_TX_SETUP;
        end else begin
          state_next_s = ST_TX_WAIT_CS;
        end
      end
      ST_TX_SETUP: begin
        state_next_s = ST_TX_STROBE;
      end
      ST_TX_STROBE: begin
        if (cs_s) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_TX_WAIT_CS;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // FSM state, wait counter and pending reply.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_r <= ST_IDLE;
      cnt_r   <= {CNT_W{1'b0}};
      reply_r <= {DATA_LEN{1'b0}};
    end else begin
      state_r <= state_next_s;
      cnt_r   <= cnt_next_s;
      reply_r <= reply_next_s;
    end
  end

  // Registered handshake strobes, TX load path and sticky status flags.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      tx_dv_r      <= 1'b0;
      tx_data_r    <= {DATA_LEN{1'b0}};
      reg_wr_r     <= 1'b0;
      reg_rd_r     <= 1'b0;
      meas_start_r <= 1'b0;
      addr_r       <= 6'd0;
      wdata_r      <= 8'd0;
      busy_r       <= 1'b0;
      overrun_r    <= 1'b0;
      timeout_r    <= 1'b0;
    end else begin
      tx_dv_r      <= (state_next_s == ST_TX_STROBE);
      reg_rd_r     <= (state_next_s == ST_RD_WAIT);
      busy_r       <= (state_next_s != ST_IDLE);
      reg_wr_r     <= accept_s && (rx_op_s == OP_WR);
      meas_start_r <= accept_s && (rx_op_s == OP_MEAS);
      if (accept_s && ((rx_op_s == OP_WR) || (rx_op_s == OP_RD))) begin
        addr_r <= i_RX_Data[ADDR_HI:ADDR_LO];
      end
      if (accept_s && (rx_op_s == OP_WR)) begin
        wdata_r <= i_RX_Data[DATA_HI:DATA_LO];
      end
      if ((state_r == ST_TX_WAIT_CS) && (state_next_s == ST_TX_SETUP)) begin
        tx_data_r <= reply_r;
      end
      if (i_RX_DV && (state_r != ST_IDLE)) begin
        overrun_r <= 1'b1;
      end
      if (timeout_hit_s) begin
        timeout_r <= 1'b1;
      end
    end
  end

  assign o_TX_DV      = tx_dv_r;
  assign o_TX_Data    = tx_data_r;
  assign o_Reg_Wr     = reg_wr_r;
  assign o_Reg_Rd     = reg_rd_r;
  assign o_Reg_Addr   = addr_r;
  assign o_Reg_WData  = wdata_r;
  assign o_Meas_Start = meas_start_r;
  assign o_Busy       = busy_r;
  assign o_Overrun    = overrun_r;
  assign o_Timeout    = timeout_r;

endmodule
